// File: rtl/time_display_scan.sv
// Snapshots the packed {hr,min,sec,ms} time word, converts each field to BCD with an
// iterative shift-add-3 engine and scans the result onto an 8-digit common-anode display.
module time_display_scan #(
  parameter int DIGIT_DIV   = 1,
  parameter bit CHECK_RANGE = 1
) (
  input  logic        kh_clk,
  input  logic        reset_n,
  input  logic [26:0] disp_time,
  input  logic        show_ms,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        err,
  output logic        frame_tick
);

  localparam int               DIV_W    = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_DIV - 1);
  localparam logic [3:0]       C_DASH   = 4'd10;
  localparam logic [3:0]       C_BLANK  = 4'd11;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       nxt_idx;
  logic [3:0]       it_cnt;
  logic             slot_start, digit0_start, load, swap, range_bad;

  logic [9:0]  bin_hr, bin_mn, bin_sc, bin_ms;
  logic [7:0]  bcd_hr, bcd_mn, bcd_sc;
  logic [11:0] bcd_ms;
  logic        snap_mode, snap_err;

  logic [7:0]  bank_hr, bank_mn, bank_sc;
  logic [11:0] bank_ms;
  logic        bank_mode, bank_err, bank_valid;

  logic [7:0]  shown_hr, shown_mn, shown_sc;
  logic [11:0] shown_ms;
  logic        shown_mode, shown_err, shown_valid;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One shift-add-3 iteration; the bit carried out of the top digit is dropped.
  function automatic logic [7:0] step8(input logic [7:0] b, input logic bit_in);
    logic [2:0] hi;
    logic [3:0] lo;
    hi = 3'(add3(b[7:4]));
    lo = add3(b[3:0]);
    return {hi, lo, bit_in};
  endfunction

  function automatic logic [11:0] step12(input logic [11:0] b, input logic bit_in);
    logic [2:0] hi;
    logic [3:0] mid, lo;
    hi  = 3'(add3(b[11:8]));
    mid = add3(b[7:4]);
    lo  = add3(b[3:0]);
    return {hi, mid, lo, bit_in};
  endfunction

  function automatic logic [3:0] digit_code(input logic [2:0] idx, input logic mode,
                                            input logic [7:0] hr, input logic [7:0] mn,
                                            input logic [7:0] sc, input logic [11:0] ms);
    logic [3:0] c;
    if (!mode) begin
      case (idx)
        3'd7:    c = hr[7:4];
        3'd6:    c = hr[3:0];
        3'd5:    c = C_DASH;
        3'd4:    c = mn[7:4];
        3'd3:    c = mn[3:0];
        3'd2:    c = C_DASH;
        3'd1:    c = sc[7:4];
        default: c = sc[3:0];
      endcase
    end else begin
      case (idx)
        3'd7:    c = mn[7:4];
        3'd6:    c = mn[3:0];
        3'd5:    c = sc[7:4];
        3'd4:    c = sc[3:0];
        3'd3:    c = C_BLANK;
        3'd2:    c = ms[11:8];
        3'd1:    c = ms[7:4];
        default: c = ms[3:0];
      endcase
    end
    return c;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] c);
    case (c)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      4'd10:   return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  assign slot_start   = (div_cnt == '0);
  assign digit0_start = slot_start && (nxt_idx == 3'd0);
  assign range_bad    = CHECK_RANGE && ((disp_time[26:22] > 5'd23) || (disp_time[21:16] > 6'd59) ||
                                        (disp_time[15:10] > 6'd59) || (disp_time[9:0] > 10'd999));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    swap    = 1'b0;
    case (state_q)
      IDLE: if (digit0_start) begin
        load    = 1'b1;
        state_d = CONV;
      end
      CONV: if (it_cnt == 4'd9) state_d = DONE;
      DONE: if (digit0_start) begin
        swap    = 1'b1;
        load    = 1'b1;
        state_d = CONV;
      end
      default: state_d = IDLE;
    endcase
  end

  // The frame being swapped in drives the outputs on the swap edge itself.
  always_comb begin
    shown_hr    = swap ? bcd_hr    : bank_hr;
    shown_mn    = swap ? bcd_mn    : bank_mn;
    shown_sc    = swap ? bcd_sc    : bank_sc;
    shown_ms    = swap ? bcd_ms    : bank_ms;
    shown_mode  = swap ? snap_mode : bank_mode;
    shown_err   = swap ? snap_err  : bank_err;
    shown_valid = swap | bank_valid;
  end

  always_ff @(posedge kh_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_cnt    <= '0;
      nxt_idx    <= 3'd0;
      it_cnt     <= 4'd0;
      bank_valid <= 1'b0;
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      err        <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt    <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      it_cnt     <= (state_q == CONV) ? it_cnt + 4'd1 : 4'd0;
      frame_tick <= swap;
      err        <= shown_valid & shown_err;
      if (swap) bank_valid <= 1'b1;
      if (slot_start) begin
        nxt_idx <= nxt_idx + 3'd1;
        an      <= ~(8'd1 << nxt_idx);
        if (!shown_valid)   seg <= 7'h7F;
        else if (shown_err) seg <= 7'h06;
        else seg <= seg_code(digit_code(nxt_idx, shown_mode, shown_hr, shown_mn, shown_sc, shown_ms));
        dp <= ~(shown_valid && !shown_err && shown_mode && (nxt_idx == 3'd6 || nxt_idx == 3'd4));
      end
    end
  end

  always_ff @(posedge kh_clk) begin
    if (load) begin
      bin_hr    <= {5'd0, disp_time[26:22]};
      bin_mn    <= {4'd0, disp_time[21:16]};
      bin_sc    <= {4'd0, disp_time[15:10]};
      bin_ms    <= disp_time[9:0];
      bcd_hr    <= 8'd0;
      bcd_mn    <= 8'd0;
      bcd_sc    <= 8'd0;
      bcd_ms    <= 12'd0;
      snap_mode <= show_ms;
      snap_err  <= range_bad;
    end else if (state_q == CONV) begin
      bin_hr <= {bin_hr[8:0], 1'b0};
      bin_mn <= {bin_mn[8:0], 1'b0};
      bin_sc <= {bin_sc[8:0], 1'b0};
      bin_ms <= {bin_ms[8:0], 1'b0};
      bcd_hr <= step8(bcd_hr, bin_hr[9]);
      bcd_mn <= step8(bcd_mn, bin_mn[9]);
      bcd_sc <= step8(bcd_sc, bin_sc[9]);
      bcd_ms <= step12(bcd_ms, bin_ms[9]);
    end
    if (swap) begin
      bank_hr   <= bcd_hr;
      bank_mn   <= bcd_mn;
      bank_sc   <= bcd_sc;
      bank_ms   <= bcd_ms;
      bank_mode <= snap_mode;
      bank_err  <= snap_err;
    end
  end

endmodule
